// File: rtl/div_sequencer.sv
// Iterative 32-bit restoring divider (DIV/DIVU/REM/REMU) that borrows a shared ALU
// for one subtraction per cycle; special cases complete without iterating.
package div_sequencer_pkg;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA
    } alu_op_e;

    typedef enum logic [1:0] {OP_ZERO, OP_REG, OP_IMM, OP_PC} op_sel_e;

    typedef struct packed {
        alu_op_e operation;
        op_sel_e op1_sel;
        op_sel_e op2_sel;
        logic    use_unsigned;
    } alu_control_t;
endpackage

module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int REG_WIDTH = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [1:0]           i_op,
    input  logic [REG_WIDTH-1:0] i_dividend,
    input  logic [REG_WIDTH-1:0] i_divisor,
    input  logic                 i_flush,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [REG_WIDTH-1:0] o_result,
    output logic                 o_busy,
    output logic                 o_alu_req,
    output alu_control_t         o_alu_control,
    output logic [REG_WIDTH-1:0] o_alu_rs1,
    output logic [REG_WIDTH-1:0] o_alu_rs2,
    input  logic [REG_WIDTH-1:0] i_alu_result,
    input  logic                 i_alu_less_than
);
    localparam int CNT_W = $clog2(REG_WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e                 state_q;
    logic [1:0]             op_q;
    logic [REG_WIDTH-1:0]   rem_q;
    logic [REG_WIDTH-1:0]   quo_q;
    logic [REG_WIDTH-1:0]   dvs_q;
    logic [REG_WIDTH-1:0]   result_q;
    logic                   neg_quo_q;
    logic                   neg_rem_q;
    logic [CNT_W-1:0]       cnt_q;

    // op[0] set means unsigned; op[1] set means remainder
    logic                   is_signed;
    logic [REG_WIDTH-1:0]   dividend_mag;
    logic [REG_WIDTH-1:0]   divisor_mag;
    logic                   div_by_zero;
    logic                   overflow;
    logic [REG_WIDTH-1:0]   shifted_rem;
    logic                   take;
    logic [REG_WIDTH-1:0]   fix_sel;
    logic                   fix_neg;

    assign is_signed    = ~i_op[0];
    assign dividend_mag = (is_signed && i_dividend[REG_WIDTH-1]) ? -i_dividend : i_dividend;
    assign divisor_mag  = (is_signed && i_divisor[REG_WIDTH-1])  ? -i_divisor  : i_divisor;
    assign div_by_zero  = (i_divisor == '0);
    assign overflow     = is_signed && (i_dividend == {1'b1, {(REG_WIDTH-1){1'b0}}})
                          && (i_divisor == '1);

    // rem[31] set means the 33-bit shifted remainder exceeds any divisor
    assign shifted_rem  = {rem_q[REG_WIDTH-2:0], quo_q[REG_WIDTH-1]};
    assign take         = rem_q[REG_WIDTH-1] | ~i_alu_less_than;
    assign fix_sel      = op_q[1] ? rem_q : quo_q;
    assign fix_neg      = op_q[1] ? neg_rem_q : neg_quo_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
        end else if (i_flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        op_q      <= i_op;
                        dvs_q     <= divisor_mag;
                        neg_quo_q <= is_signed && (i_dividend[REG_WIDTH-1] ^ i_divisor[REG_WIDTH-1]);
                        neg_rem_q <= is_signed && i_dividend[REG_WIDTH-1];
                        if (div_by_zero) begin
                            result_q <= i_op[1] ? i_dividend : '1;
                            state_q  <= DONE;
                        end else if (overflow) begin
                            result_q <= i_op[1] ? '0 : {1'b1, {(REG_WIDTH-1){1'b0}}};
                            state_q  <= DONE;
                        end else begin
                            rem_q   <= '0;
                            quo_q   <= dividend_mag;
                            cnt_q   <= '0;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= take ? i_alu_result : shifted_rem;
                    quo_q <= {quo_q[REG_WIDTH-2:0], take};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(REG_WIDTH-1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    result_q <= fix_neg ? -fix_sel : fix_sel;
                    state_q  <= DONE;
                end
                DONE: begin
                    if (i_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ready   = (state_q == IDLE);
    assign o_busy    = (state_q != IDLE);
    assign o_valid   = (state_q == DONE);
    assign o_alu_req = (state_q == CALC);
    assign o_result  = result_q;
    assign o_alu_rs1 = o_alu_req ? shifted_rem : '0;
    assign o_alu_rs2 = o_alu_req ? dvs_q : '0;

    always_comb begin
        o_alu_control.operation    = OP_ADD;
        o_alu_control.op1_sel      = OP_ZERO;
        o_alu_control.op2_sel      = OP_ZERO;
        o_alu_control.use_unsigned = 1'b0;
        if (o_alu_req) begin
            o_alu_control.operation    = OP_SUB;
            o_alu_control.op1_sel      = OP_REG;
            o_alu_control.op2_sel      = OP_REG;
            o_alu_control.use_unsigned = 1'b1;
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: a shared-ALU model, an arithmetic reference
// model checked every cycle, and hand-computed literal expectations per operation.
module tb_div_sequencer;
    import div_sequencer_pkg::*;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic         o_ready;
    logic [1:0]   i_op = 2'd0;
    logic [31:0]  i_dividend = '0;
    logic [31:0]  i_divisor = '0;
    logic         i_flush = 1'b0;
    logic         o_valid;
    logic         i_ready = 1'b0;
    logic [31:0]  o_result;
    logic         o_busy;
    logic         o_alu_req;
    alu_control_t o_alu_control;
    logic [31:0]  o_alu_rs1;
    logic [31:0]  o_alu_rs2;
    logic [31:0]  i_alu_result;
    logic         i_alu_less_than;

    int vectors = 0;
    int errors  = 0;
    int req_cnt = 0;

    div_sequencer #(.REG_WIDTH(32)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_op(i_op), .i_dividend(i_dividend), .i_divisor(i_divisor), .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_busy(o_busy),
        .o_alu_req(o_alu_req), .o_alu_control(o_alu_control), .o_alu_rs1(o_alu_rs1),
        .o_alu_rs2(o_alu_rs2), .i_alu_result(i_alu_result), .i_alu_less_than(i_alu_less_than)
    );

    always #5 i_clk = ~i_clk;

    // Shared ALU: combinational subtract and unsigned compare
    assign i_alu_result    = o_alu_rs1 - o_alu_rs2;
    assign i_alu_less_than = (o_alu_rs1 < o_alu_rs2);

    function automatic logic is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            2'd0:    return 32'($signed(a) / $signed(b));
            2'd1:    return a / b;
            2'd2:    return 32'($signed(a) % $signed(b));
            default: return a % b;
        endcase
    endfunction

    // Reference model: one outstanding request, result visible after lat_m edges
    logic        busy_m = 1'b0;
    int          cyc_m = 0;
    int          lat_m = 1;
    logic [31:0] exp_res_m = '0;
    logic [31:0] mag_m = '0;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_m <= 1'b0;
        end else if (i_flush) begin
            busy_m <= 1'b0;
        end else if (!busy_m) begin
            if (i_valid) begin
                busy_m    <= 1'b1;
                cyc_m     <= 0;
                lat_m     <= is_special(i_op, i_dividend, i_divisor) ? 1 : 34;
                exp_res_m <= ref_div(i_op, i_dividend, i_divisor);
                mag_m     <= (!i_op[0] && i_divisor[31]) ? -i_divisor : i_divisor;
            end
        end else if (cyc_m + 1 >= lat_m && i_ready) begin
            busy_m <= 1'b0;
        end else begin
            cyc_m <= cyc_m + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    initial begin
        alu_control_t exp_ctrl;
        logic         exp_valid;
        logic         exp_req;
        forever begin
            @(negedge i_clk);
            if (i_rst_n) begin
                exp_valid = busy_m && (cyc_m + 1 >= lat_m);
                exp_req   = busy_m && (lat_m == 34) && (cyc_m < 32);
                exp_ctrl.operation    = exp_req ? OP_SUB : OP_ADD;
                exp_ctrl.op1_sel      = exp_req ? OP_REG : OP_ZERO;
                exp_ctrl.op2_sel      = exp_req ? OP_REG : OP_ZERO;
                exp_ctrl.use_unsigned = exp_req;
                chk("cyc_ready",   32'(o_ready),   32'(!busy_m));
                chk("cyc_busy",    32'(o_busy),    32'(busy_m));
                chk("cyc_valid",   32'(o_valid),   32'(exp_valid));
                chk("cyc_alu_req", 32'(o_alu_req), 32'(exp_req));
                chk("cyc_alu_ctrl", 32'(o_alu_control), 32'(exp_ctrl));
                if (exp_valid) chk("cyc_result", o_result, exp_res_m);
                if (exp_req)   chk("cyc_alu_rs2", o_alu_rs2, mag_m);
                if (o_alu_req) req_cnt++;
            end
        end
    end

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lit, input int lat_lit, input int hold);
        int          c;
        int          req0;
        logic [31:0] r0;
        chk("model_pin", ref_div(op, a, b), exp_lit);
        @(negedge i_clk);
        chk("idle_ready", 32'(o_ready), 32'd1);
        i_valid = 1'b1; i_op = op; i_dividend = a; i_divisor = b; i_ready = 1'b0;
        req0 = req_cnt;
        @(negedge i_clk);
        i_valid = 1'b0;
        i_op = 2'($urandom);
        i_dividend = $urandom;
        i_divisor = $urandom;
        c = 0;
        while (!o_valid && c < 60) begin
            @(negedge i_clk);
            c++;
        end
        chk("latency", 32'(c + 1), 32'(lat_lit));
        chk("result", o_result, exp_lit);
        if (lat_lit == 34) chk("alu_req_cycles", 32'(req_cnt - req0), 32'd32);
        $display("op=%0d a=%h b=%h result=%h latency=%0d", op, a, b, o_result, c + 1);
        r0 = o_result;
        repeat (hold) begin
            @(negedge i_clk);
            chk("hold_valid", 32'(o_valid), 32'd1);
            chk("hold_result", o_result, r0);
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        chk("after_done_valid", 32'(o_valid), 32'd0);
        chk("after_done_ready", 32'(o_ready), 32'd1);
    endtask

    initial begin
        int c;
        // Reset values
        repeat (2) @(negedge i_clk);
        #1;
        chk("rst_valid",   32'(o_valid),   32'd0);
        chk("rst_busy",    32'(o_busy),    32'd0);
        chk("rst_alu_req", 32'(o_alu_req), 32'd0);
        chk("rst_result",  o_result,       32'd0);
        @(negedge i_clk);
        #2 i_rst_n = 1'b1;
        @(negedge i_clk);
        chk("rst_ready", 32'(o_ready), 32'd1);

        run_op(2'd1, 32'd100, 32'd7, 32'd14, 34, 10);
        run_op(2'd3, 32'd100, 32'd7, 32'd2, 34, 0);
        run_op(2'd0, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 34, 0);
        run_op(2'd2, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 34, 0);
        run_op(2'd0, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 34, 0);
        run_op(2'd2, 32'd20, 32'hFFFF_FFFD, 32'd2, 34, 0);
        run_op(2'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 34, 0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 34, 0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 34, 0);
        run_op(2'd3, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 34, 0);
        run_op(2'd1, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 3);
        run_op(2'd2, 32'd5, 32'd0, 32'd5, 1, 0);
        run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);

        // Flush at CALC cycle 10
        @(negedge i_clk);
        i_valid = 1'b1; i_op = 2'd1; i_dividend = 32'd1000; i_divisor = 32'd3; i_ready = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (9) @(negedge i_clk);
        chk("pre_flush_busy", 32'(o_busy), 32'd1);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        chk("flush_ready", 32'(o_ready), 32'd1);
        chk("flush_valid", 32'(o_valid), 32'd0);
        c = 0;
        repeat (40) begin
            @(negedge i_clk);
            if (o_valid) c++;
        end
        chk("flush_no_result", 32'(c), 32'd0);
        $display("flush mid-CALC: result dropped, o_ready=%0d", o_ready);

        // Flush beats a same-cycle request
        i_valid = 1'b1; i_flush = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0; i_flush = 1'b0;
        chk("flush_vs_valid_busy", 32'(o_busy), 32'd0);
        i_ready = 1'b0;

        // Asynchronous reset mid-CALC
        i_valid = 1'b1; i_op = 2'd1; i_dividend = 32'd100; i_divisor = 32'd7;
        @(negedge i_clk);
        i_valid = 1'b0;
        repeat (5) @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        chk("async_rst_valid",   32'(o_valid),   32'd0);
        chk("async_rst_busy",    32'(o_busy),    32'd0);
        chk("async_rst_alu_req", 32'(o_alu_req), 32'd0);
        chk("async_rst_result",  o_result,       32'd0);
        $display("async reset mid-CALC: busy=%0d valid=%0d", o_busy, o_valid);
        repeat (2) @(negedge i_clk);
        #2 i_rst_n = 1'b1;
        run_op(2'd1, 32'd9, 32'd2, 32'd4, 34, 0);

        repeat (3) @(negedge i_clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 Parameter REG_WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 i_clk  input  1  clock, all state updates on rising edge.
REQ-004 i_rst_n  input  1  asynchronous active-low reset.
REQ-005 i_valid  input  1  request valid.
REQ-006 o_ready  output  1  request accepted when i_valid && o_ready.
REQ-007 i_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-008 i_dividend  input  REG_WIDTH  dividend.
REQ-009 i_divisor  input  REG_WIDTH  divisor.
REQ-010 i_flush  input  1  abort the in-flight operation.
REQ-011 o_valid  output  1  result valid.
REQ-012 i_ready  input  1  result consumed when o_valid && i_ready.
REQ-013 o_result  output  REG_WIDTH  quotient (DIV/DIVU) or remainder (REM/REMU).
REQ-014 o_busy  output  1  high in any state other than IDLE.
REQ-015 o_alu_req  output  1  ALU claimed; high only in CALC.
REQ-016 o_alu_control  output  alu_control_t  drive to the shared ALU.
REQ-017 o_alu_rs1  output  REG_WIDTH  ALU operand 1 (shifted partial remainder).
REQ-018 o_alu_rs2  output  REG_WIDTH  ALU operand 2 (magnitude of divisor).
REQ-019 i_alu_result  input  REG_WIDTH  ALU subtraction result, same cycle.
REQ-020 i_alu_less_than  input  1  ALU unsigned less-than flag, same cycle.

Function
REQ-021 FSM states IDLE, CALC, FIX and DONE; o_ready = (state == IDLE).
REQ-022 On acceptance, the block latches the op, operand magnitudes (two's-complement negation for negative DIV/REM operands) and the result sign flags.
REQ-023 Sign flags: quotient negative iff the operand signs differ; remainder takes the dividend sign.
REQ-024 Divisor == 0 at acceptance: IDLE->DONE; result all-ones (DIV/DIVU), dividend (REM/REMU).
REQ-025 Signed overflow at acceptance (DIV/REM, dividend 0x80000000, divisor 0xFFFFFFFF): IDLE->DONE; result 0x80000000 (DIV), 0 (REM).
REQ-026 Otherwise IDLE->CALC with remainder=0, quotient=|dividend| and iteration counter=0.
REQ-027 CALC, one iteration per cycle: o_alu_rs1 = {rem[30:0], quo[31]}; o_alu_rs2 = |divisor|.
REQ-028 In CALC, o_alu_control = operation OP_SUB, op1_sel OP_REG, op2_sel OP_REG, use_unsigned 1; outside CALC it is OP_ADD, OP_ZERO, OP_ZERO, use_unsigned 0.
REQ-029 Take step when rem[31]==1 or i_alu_less_than==0: rem<=i_alu_result, quo<={quo[30:0],1}; else rem<=o_alu_rs1, quo<={quo[30:0],0}.
REQ-030 After exactly 32 CALC cycles (counter 31 to wrap), CALC->FIX.
REQ-031 FIX, one cycle: select quotient or remainder, negate if its sign flag is set, register into o_result; FIX->DONE.
REQ-032 DONE: o_valid=1, o_result held stable until i_valid-independent i_ready; on i_ready DONE->IDLE.
REQ-033 Latency: acceptance at edge N gives o_valid from edge N+34 (normal) or N+1 (special cases).
REQ-034 No new request is accepted in the cycle DONE is left; the next acceptance is earliest one cycle later.
REQ-035 i_flush in any state forces IDLE next edge, clears o_valid, and drops the pending result; i_flush wins over i_valid and i_ready in the same cycle.
REQ-036 Operands and op changing after acceptance have no effect on the in-flight result.

Reset
REQ-037 While i_rst_n==0: state IDLE, o_valid=0, o_busy=0, o_alu_req=0, o_result=0, counter=0, o_ready=1 after reset release.
REQ-038 Reset asserted mid-CALC aborts immediately, asynchronously, without producing a result.

Verification
REQ-039 DIVU 100/7 -> 14 at acceptance+34; REMU 100/7 -> 2; o_alu_req high exactly 32 cycles.
REQ-040 DIV 0xFFFFFFEC(-20)/3 -> 0xFFFFFFFA; REM -> 0xFFFFFFFE; DIV 20/0xFFFFFFFD -> 0xFFFFFFFA, REM -> 2.
REQ-041 DIVU 0xFFFFFFFF/0x80000001 -> 1; REMU -> 0x7FFFFFFE (exercises rem[31] take path).
REQ-042 DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; all at acceptance+1.
REQ-043 i_ready held low 10 cycles in DONE -> o_valid and o_result stable; flush at CALC cycle 10 -> IDLE next edge, o_ready=1, no o_valid.
REQ-044 i_rst_n pulsed low mid-CALC -> all outputs at reset values without a clock edge; next DIVU 9/2 -> 4.
